// File: rtl/sec_b2a_hs.sv
// Handshaked masked Boolean-to-arithmetic share converter around a fixed-latency core.
// Define SEC_B2A_REFRESH_EN to add an output arithmetic-refresh stage (REFR, +1 cycle).
module sec_b2a_hs #(
    parameter int K_WIDTH = 32,
    parameter int N_SHARES = 8,
    localparam int RAND_INIT = N_SHARES - 1,
    localparam int RAND_A2B = N_SHARES - 1,
    localparam int RAND_KSA = 0,
    localparam int RAND_FXOR = N_SHARES - 1,
`ifdef SEC_B2A_REFRESH_EN
    localparam int RND_WORDS = RAND_INIT + RAND_A2B + RAND_KSA + RAND_FXOR + N_SHARES - 1,
`else
    localparam int RND_WORDS = RAND_INIT + RAND_A2B + RAND_KSA + RAND_FXOR,
`endif
    localparam int LAT_CORE = N_SHARES + 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          i_vld,
    output logic                          o_rdy,
    input  logic [K_WIDTH*N_SHARES-1:0]   i_b,
    input  logic                          rnd_vld,
    output logic                          rnd_rdy,
    input  logic [K_WIDTH*RND_WORDS-1:0]  rnd,
    input  logic                          i_clr,
    output logic                          o_vld,
    input  logic                          i_rdy,
    output logic [K_WIDTH*N_SHARES-1:0]   o_a,
    output logic                          o_err
);
    localparam int WD_LIMIT = LAT_CORE + 3;
    localparam int WD_W = $clog2(LAT_CORE + 4) + 1;
    localparam int FXOR_BASE = RAND_INIT + RAND_A2B + RAND_KSA;

    typedef logic [K_WIDTH-1:0] word_t;
    typedef logic [N_SHARES-1:0][K_WIDTH-1:0] shares_t;

`ifdef SEC_B2A_REFRESH_EN
    typedef enum logic [2:0] {IDLE, CONV, REFR, HOLD, DRAIN} state_t;
`else
    typedef enum logic [2:0] {IDLE, CONV, HOLD, DRAIN} state_t;
`endif

    state_t                                   state_reg;
    shares_t                                  b_reg;
    logic [RND_WORDS-1:0][K_WIDTH-1:0]        rnd_reg;
    logic                                     dvld_reg;
    logic                                     o_rdy_reg;
    logic                                     o_vld_reg;
    logic                                     o_err_reg;
    shares_t                                  o_a_reg;
    logic [WD_W-1:0]                          wdog_reg;
    logic [LAT_CORE-1:0][N_SHARES-1:0][K_WIDTH-1:0] pipe_reg;
    logic [LAT_CORE-1:0][N_SHARES-1:0][K_WIDTH-1:0] pipe_next;
    logic [LAT_CORE-1:0]                      vld_reg;
    word_t                                    acc;
    word_t                                    mask;
    word_t                                    fsum;
    logic                                     accept;
    logic                                     core_ovld;
    shares_t                                  core_out;

    // Goubin: ((x'^r)-r) is affine in r, so split r with fresh g to keep every term masked.
    function automatic word_t goubin(word_t xp, word_t r, word_t g);
        word_t t0;
        word_t t1;
        t0 = ((xp ^ g) - g) ^ xp;
        t1 = (xp ^ (r ^ g)) - (r ^ g);
        return t0 ^ t1;
    endfunction

    // Core: Boolean refresh, N-1 Goubin steps peeling one share each, arithmetic refresh.
    always_comb begin
        pipe_next = pipe_reg;
        acc = '0;
        mask = '0;
        fsum = '0;
        for (int i = 0; i < N_SHARES - 1; i++) begin
            pipe_next[0][i] = b_reg[i] ^ rnd_reg[i];
            acc = acc ^ rnd_reg[i];
        end
        pipe_next[0][N_SHARES-1] = b_reg[N_SHARES-1] ^ acc;
        for (int s = 1; s < N_SHARES; s++) begin
            pipe_next[s] = pipe_reg[s-1];
            mask = '0;
            for (int k = s; k < N_SHARES; k++) begin
                mask = mask ^ pipe_reg[s-1][k];
            end
            pipe_next[s][s-1] = goubin(pipe_reg[s-1][s-1], mask, rnd_reg[RAND_INIT+s-1]);
        end
        pipe_next[N_SHARES] = pipe_reg[N_SHARES-1];
        for (int i = 0; i < N_SHARES - 1; i++) begin
            pipe_next[N_SHARES][i] = pipe_reg[N_SHARES-1][i] + rnd_reg[FXOR_BASE+i];
            fsum = fsum + rnd_reg[FXOR_BASE+i];
        end
        pipe_next[N_SHARES][N_SHARES-1] = pipe_reg[N_SHARES-1][N_SHARES-1] - fsum;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pipe_reg <= '0;
            vld_reg <= '0;
        end else begin
            pipe_reg <= pipe_next;
            vld_reg <= {vld_reg[LAT_CORE-2:0], dvld_reg};
        end
    end

    assign core_ovld = vld_reg[LAT_CORE-1];
    assign core_out = pipe_reg[LAT_CORE-1];

`ifdef SEC_B2A_REFRESH_EN
    localparam int REFR_BASE = RND_WORDS - (N_SHARES - 1);
    shares_t res_reg;
    shares_t refr_out;
    word_t   refr_total;

    always_comb begin
        refr_total = '0;
        for (int i = 0; i < N_SHARES - 1; i++) begin
            refr_total = refr_total + rnd_reg[REFR_BASE+i];
        end
    end

    for (genvar gi = 0; gi < N_SHARES - 1; gi++) begin : g_refr
        assign refr_out[gi] = res_reg[gi] + rnd_reg[REFR_BASE+gi];
    end
    assign refr_out[N_SHARES-1] = res_reg[N_SHARES-1] - refr_total;
`endif

    assign accept = o_rdy_reg && i_vld && rnd_vld;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            b_reg <= '0;
            rnd_reg <= '0;
            dvld_reg <= 1'b0;
            o_rdy_reg <= 1'b1;
            o_vld_reg <= 1'b0;
            o_err_reg <= 1'b0;
            o_a_reg <= '0;
            wdog_reg <= '0;
`ifdef SEC_B2A_REFRESH_EN
            res_reg <= '0;
`endif
        end else begin
            dvld_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        b_reg <= i_b;
                        rnd_reg <= rnd;
                        dvld_reg <= 1'b1;
                        wdog_reg <= '0;
                        o_rdy_reg <= 1'b0;
                        state_reg <= CONV;
                    end
                end
                CONV: begin
                    if (i_clr) begin
                        // An ovld arriving with the abort is already drained.
                        if (core_ovld) begin
                            state_reg <= IDLE;
                            o_rdy_reg <= 1'b1;
                        end else begin
                            state_reg <= DRAIN;
                            wdog_reg <= wdog_reg + 1'b1;
                        end
                    end else if (core_ovld) begin
`ifdef SEC_B2A_REFRESH_EN
                        res_reg <= core_out;
                        state_reg <= REFR;
`else
                        o_a_reg <= core_out;
                        o_vld_reg <= 1'b1;
                        state_reg <= HOLD;
`endif
                    end else if (wdog_reg == WD_W'(WD_LIMIT)) begin
                        o_err_reg <= 1'b1;
                        state_reg <= IDLE;
                        o_rdy_reg <= 1'b1;
                    end else begin
                        wdog_reg <= wdog_reg + 1'b1;
                    end
                end
`ifdef SEC_B2A_REFRESH_EN
                REFR: begin
                    if (i_clr) begin
                        state_reg <= IDLE;
                        o_rdy_reg <= 1'b1;
                    end else begin
                        o_a_reg <= refr_out;
                        o_vld_reg <= 1'b1;
                        state_reg <= HOLD;
                    end
                end
`endif
                HOLD: begin
                    if (i_clr || i_rdy) begin
                        o_vld_reg <= 1'b0;
                        o_a_reg <= '0;
                        state_reg <= IDLE;
                        o_rdy_reg <= 1'b1;
                    end
                end
                DRAIN: begin
                    if (core_ovld) begin
                        state_reg <= IDLE;
                        o_rdy_reg <= 1'b1;
                    end else if (wdog_reg == WD_W'(WD_LIMIT)) begin
                        o_err_reg <= 1'b1;
                        state_reg <= IDLE;
                        o_rdy_reg <= 1'b1;
                    end else begin
                        wdog_reg <= wdog_reg + 1'b1;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    o_rdy_reg <= 1'b1;
                    o_vld_reg <= 1'b0;
                    o_a_reg <= '0;
                end
            endcase
        end
    end

    assign o_rdy = o_rdy_reg;
    assign rnd_rdy = accept;
    assign o_vld = o_vld_reg;
    assign o_a = o_a_reg;
    assign o_err = o_err_reg;
endmodule

// File: tb/tb_sec_b2a_hs.sv
// Scoreboard bench for sec_b2a_hs (K=32, N=3): arithmetic sums, latency, stalls, aborts, reset.
module tb_sec_b2a_hs;
    localparam int K = 32;
    localparam int N = 3;
    localparam int LAT = N + 1;
`ifdef SEC_B2A_REFRESH_EN
    localparam int RW = 4 * (N - 1);
    localparam int OUT_LAT = LAT + 3;
`else
    localparam int RW = 3 * (N - 1);
    localparam int OUT_LAT = LAT + 2;
`endif

    logic             clk = 1'b0;
    logic             rst_n;
    logic             i_vld;
    logic             o_rdy;
    logic [N*K-1:0]   i_b;
    logic             rnd_vld;
    logic             rnd_rdy;
    logic [RW*K-1:0]  rnd;
    logic             i_clr;
    logic             o_vld;
    logic             i_rdy;
    logic [N*K-1:0]   o_a;
    logic             o_err;

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;
    logic [K-1:0] exp_q[$];

    sec_b2a_hs #(.K_WIDTH(K), .N_SHARES(N)) dut (
        .clk(clk), .rst_n(rst_n), .i_vld(i_vld), .o_rdy(o_rdy), .i_b(i_b),
        .rnd_vld(rnd_vld), .rnd_rdy(rnd_rdy), .rnd(rnd), .i_clr(i_clr),
        .o_vld(o_vld), .i_rdy(i_rdy), .o_a(o_a), .o_err(o_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [K-1:0] xor_shares(input logic [N*K-1:0] v);
        logic [K-1:0] r = '0;
        for (int i = 0; i < N; i++) r = r ^ v[i*K +: K];
        return r;
    endfunction

    function automatic logic [K-1:0] sum_shares(input logic [N*K-1:0] v);
        logic [K-1:0] r = '0;
        for (int i = 0; i < N; i++) r = r + v[i*K +: K];
        return r;
    endfunction

    // Called just after a negedge; returns just after the negedge following the accept.
    task automatic send(input logic [N*K-1:0] b, input bit keep, output int t_acc);
        i_b = b;
        for (int w = 0; w < RW; w++) rnd[w*K +: K] = $urandom();
        i_vld = 1'b1;
        rnd_vld = 1'b1;
        t_acc = -1;
        for (int i = 0; i < 50; i++) begin
            #1;
            if (rnd_rdy) begin
                t_acc = cyc;
                break;
            end
            @(negedge clk);
        end
        check("accepted", {127'b0, t_acc >= 0}, 128'd1);
        if (t_acc >= 0 && keep) exp_q.push_back(xor_shares(b));
        @(posedge clk);
        #1;
        i_vld = 1'b0;
        rnd_vld = 1'b0;
        @(negedge clk);
        if (t_acc >= 0) check("busy_after_accept", o_rdy, 0);
    endtask

    task automatic wait_vld(output int t_out);
        t_out = -1;
        for (int i = 0; i < 100; i++) begin
            if (o_vld) begin
                t_out = cyc;
                break;
            end
            @(negedge clk);
        end
        check("o_vld_seen", {127'b0, t_out >= 0}, 128'd1);
    endtask

    // At a negedge with o_vld high and i_rdy high: score the result, then confirm return to IDLE.
    task automatic take();
        logic [K-1:0] e;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        check("arith_sum", sum_shares(o_a), e);
        @(negedge clk);
        check("o_vld_one_cycle", o_vld, 0);
        check("o_rdy_after_hs", o_rdy, 1);
        check("o_a_zero_idle", {127'b0, o_a == '0}, 128'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: got no finish, required finish before time limit");
        $fatal(1, "timeout");
    end

    initial begin
        int ta, tv, t_now, prev, seen, bad, nv, t_rdy;
        logic [N*K-1:0] snap, b;
        int offs[2] = '{5, 2};

        rst_n = 1'b0; i_vld = 1'b0; rnd_vld = 1'b0; i_b = '0; rnd = '0;
        i_clr = 1'b0; i_rdy = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_o_rdy", o_rdy, 1);
        check("rst_o_vld", o_vld, 0);
        check("rst_o_err", o_err, 0);
        check("rst_o_a", o_a, 0);
        check("rst_rnd_rdy", rnd_rdy, 0);

        // Basic conversion and latency
        send({32'h12345678, 32'h12345678, 32'h00000005}, 1, ta);
        wait_vld(tv);
        check("latency", tv - ta, OUT_LAT);
        take();
        $display("item basic: accept %0d valid %0d", ta, tv);

        // Randomness not valid: no accept, no consumption
        i_b = {32'hA5A5A5A5, 32'h0F0F0F0F, 32'h11111111};
        i_vld = 1'b1; rnd_vld = 1'b0; seen = 0;
        repeat (10) begin
            #1;
            if (rnd_rdy || !o_rdy) seen++;
            @(negedge clk);
        end
        check("stall_no_accept", seen, 0);
        t_now = cyc;
        send({32'hA5A5A5A5, 32'h0F0F0F0F, 32'h11111111}, 1, ta);
        check("accept_same_cycle", ta, t_now);
        wait_vld(tv);
        take();
        $display("item rnd-stall: accept %0d valid %0d", ta, tv);

        // Downstream back-pressure in HOLD
        i_rdy = 1'b0;
        send({32'hDEADBEEF, 32'h01234567, 32'h89ABCDEF}, 1, ta);
        wait_vld(tv);
        snap = o_a; bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (o_a !== snap || o_rdy !== 1'b0 || o_vld !== 1'b1) bad++;
        end
        check("hold_stable", bad, 0);
        i_rdy = 1'b1;
        take();
        $display("item backpressure: accept %0d valid %0d", ta, tv);

        // Abort in CONV: coincident with core ovld (5) and early (2)
        foreach (offs[j]) begin
            send({32'h5555AAAA, 32'h33333333, 32'h77777777}, 0, ta);
            while (cyc < ta + offs[j]) @(negedge clk);
            i_clr = 1'b1;
            nv = 0; t_rdy = -1;
            for (int i = 0; i < 30; i++) begin
                @(negedge clk);
                i_clr = 1'b0;
                if (o_vld) nv++;
                if (o_rdy && t_rdy < 0) t_rdy = cyc;
            end
            check("clr_no_o_vld", nv, 0);
            check("clr_o_rdy_time", t_rdy - ta, LAT + 2);
            check("clr_no_err", o_err, 0);
            $display("item clear at +%0d: accept %0d ready %0d", offs[j], ta, t_rdy);
        end

        // Abort in HOLD
        i_rdy = 1'b0;
        send({32'h13579BDF, 32'h2468ACE0, 32'hFEDCBA98}, 0, ta);
        wait_vld(tv);
        i_clr = 1'b1;
        @(negedge clk);
        i_clr = 1'b0;
        check("hold_clr_o_vld", o_vld, 0);
        check("hold_clr_o_rdy", o_rdy, 1);
        check("hold_clr_o_a", {127'b0, o_a == '0}, 128'd1);
        i_rdy = 1'b1;
        $display("item hold clear: accept %0d valid %0d", ta, tv);

        // Wrap-around value
        send({32'h00000000, 32'h0000FFFF, 32'hFFFF0000}, 1, ta);
        wait_vld(tv);
        take();
        $display("item wrap: accept %0d valid %0d", ta, tv);

        // Reset in the middle of a conversion
        send({32'h0BADF00D, 32'hCAFEBABE, 32'h600DD00D}, 0, ta);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        nv = 0;
        repeat (20) begin
            @(negedge clk);
            if (o_vld) nv++;
        end
        check("rst_mid_no_o_vld", nv, 0);
        check("rst_mid_no_err", o_err, 0);
        check("rst_mid_o_rdy", o_rdy, 1);
        $display("item reset mid-conv: accept %0d", ta);

        // Random items back to back
        prev = -1;
        for (int k = 0; k < 6; k++) begin
            b = {$urandom(), $urandom(), $urandom()};
            send(b, 1, ta);
            if (prev >= 0) check("b2b_interval", ta - prev, OUT_LAT + 1);
            prev = ta;
            wait_vld(tv);
            check("latency_rand", tv - ta, OUT_LAT);
            take();
            $display("item rand %0d: x=0x%08h accept %0d valid %0d", k, xor_shares(b), ta, tv);
        end

        check("sb_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/sec_b2a_hs.md
SEC_B2A_HS -- requirements
Module: sec_b2a_hs

Interface
REQ-001 SHALL have parameter K_WIDTH, default 32, share word width in bits; arithmetic modulus is 2^K_WIDTH.
REQ-002 SHALL have parameter N_SHARES, default 8, number of shares (>=2).
REQ-003 SHALL have localparam RND_WORDS = RAND_INIT+RAND_A2B+RAND_KSA+RAND_FXOR (+N_SHARES-1 when SEC_B2A_REFRESH_EN is defined), computed as for the codebase B2A core.
REQ-004 SHALL have localparam LAT_CORE, equal to the core's documented dvld-to-ovld latency.
REQ-005 SHALL have clk  input  1  single clock; all logic rising-edge.
REQ-006 SHALL have rst_n  input  1  reset, synchronous and active-low.
REQ-007 SHALL have i_vld  input  1  input shares valid.
REQ-008 SHALL have o_rdy  output  1  block ready for input.
REQ-009 SHALL have i_b  input  K_WIDTH*N_SHARES  Boolean shares, share i at [i*K_WIDTH +: K_WIDTH].
REQ-010 SHALL have rnd_vld  input  1  fresh randomness valid.
REQ-011 SHALL have rnd_rdy  output  1  randomness consumed (1-cycle pulse).
REQ-012 SHALL have rnd  input  K_WIDTH*RND_WORDS  fresh randomness.
REQ-013 SHALL have i_clr  input  1  synchronous abort of the conversion in flight.
REQ-014 SHALL have o_vld  output  1  arithmetic result valid.
REQ-015 SHALL have i_rdy  input  1  downstream ready.
REQ-016 SHALL have o_a  output  K_WIDTH*N_SHARES  arithmetic shares, same packing as i_b.
REQ-017 SHALL have o_err  output  1  sticky watchdog error.

Function
REQ-018 SHALL implement FSM states IDLE, CONV, [REFR], HOLD, DRAIN; REFR exists only with SEC_B2A_REFRESH_EN.
REQ-019 SHALL assert o_rdy only in IDLE; accept occurs in a cycle with o_rdy&&i_vld&&rnd_vld; rnd_rdy SHALL pulse high in exactly that cycle.
REQ-020 SHALL ignore i_vld while rnd_vld is low, without accepting input or consuming randomness.
REQ-021 SHALL register i_b and rnd on accept and drive the core only from these registers until the conversion leaves CONV.
REQ-022 SHALL pulse core dvld one cycle after accept (cycle T+1 for accept at T); core ena held high.
REQ-023 SHALL capture core output on core ovld (cycle T+1+LAT_CORE) and enter HOLD (or REFR); o_vld first high at T+2+LAT_CORE (T+3+LAT_CORE with refresh).
REQ-024 SHALL keep o_vld and o_a stable in HOLD until o_vld&&i_rdy, then return to IDLE next cycle; minimum back-to-back accept interval LAT_CORE+3 cycles.
REQ-025 SHALL satisfy sum of o_a shares mod 2^K_WIDTH == XOR of captured i_b shares; addition wraps mod 2^K_WIDTH.
REQ-026 SHALL, on i_clr in CONV, go to DRAIN: o_rdy low, o_vld low, core ovld consumed and discarded, then IDLE.
REQ-027 SHALL, on i_clr in HOLD or REFR, drop o_vld and go to IDLE next cycle; i_clr in IDLE/DRAIN has no effect.
REQ-028 SHALL run a watchdog counter in CONV/DRAIN; if core ovld is absent for LAT_CORE+4 cycles after dvld, set o_err (sticky) and go to IDLE.
REQ-029 SHALL give i_clr priority over simultaneous core ovld and over i_rdy.
REQ-030 SHALL never drive o_a with unmasked combinations of shares; o_a is zero outside HOLD.

Reset
REQ-031 SHALL, with rst_n low at a clock edge, enter IDLE and clear o_vld=0, rnd_rdy=0, o_err=0, o_a=0, watchdog=0, o_rdy=1 from the first cycle after release.
REQ-032 SHALL reset the internal core and share-delay pipelines too, so reset mid-conversion yields no later o_vld.

Configuration
REQ-033 SHALL, with SEC_B2A_REFRESH_EN defined, add REFR state: share i<N_SHARES-1 gets +r_i, last share gets -sum r_i mod 2^K_WIDTH, r_i from the top N_SHARES-1 rnd words; +1 cycle latency.
REQ-034 SHALL, without SEC_B2A_REFRESH_EN, go from CONV directly to HOLD, and RND_WORDS excludes the refresh words.

Verification
REQ-035 SHALL cover: K=32,N=3, i_b={0x12345678,0x12345678,0x00000005} with random rnd -> o_a sums to 0x00000005 mod 2^32.
REQ-036 SHALL cover: accept at cycle T, i_rdy=1 -> o_vld first high at T+2+LAT_CORE (T+3+LAT_CORE with macro), one-cycle handshake.
REQ-037 SHALL cover: i_vld=1, rnd_vld=0 for 10 cycles -> no rnd_rdy, no accept; rnd_vld=1 -> accept same cycle.
REQ-038 SHALL cover: i_rdy=0 for 20 cycles in HOLD -> o_a constant, o_rdy=0; i_rdy=1 -> IDLE next cycle.
REQ-039 SHALL cover: i_clr at T+5 -> no o_vld for that item; o_rdy high again one cycle after core ovld.
REQ-040 SHALL cover: XOR of i_b = 0xFFFFFFFF -> o_a sums to 0xFFFFFFFF (wrap); rst_n low mid-CONV -> no o_vld, o_err=0.
